// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// EX acts as master: it presents an operation and watches stall/done/result.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1_data, rs2_data, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/mdu_seq.sv
// RV32M sequencer: 32-step shift-add multiply / restoring divide on magnitudes,
// sign fix-up at the end, single-cycle handling of divide-by-zero and signed overflow.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_seq_if.slave   bus
);
    localparam int CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [XLEN-1:0] hi_reg, hi_next;
    logic [XLEN-1:0] lo_reg, lo_next;
    logic [XLEN-1:0] opb_reg, opb_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [2:0]      op_reg, op_next;
    logic            neg_reg, neg_next;
    logic            nega_reg, nega_next;

    logic            signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            rs2_zero, overflow, fast_path;
    logic [XLEN-1:0] fast_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_result;
    logic              done;

    // Operand decode for the request currently presented on the bus
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            3'b010:  signed_a = 1'b1;
            default: ;
        endcase
        sign_a   = signed_a & bus.rs1_data[XLEN-1];
        sign_b   = signed_b & bus.rs2_data[XLEN-1];
        mag_a    = sign_a ? -bus.rs1_data : bus.rs1_data;
        mag_b    = sign_b ? -bus.rs2_data : bus.rs2_data;
        rs2_zero = (bus.rs2_data == '0);
        overflow = (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1)
                   && (bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
        fast_path   = bus.funct3[2] && (rs2_zero || overflow);
        fast_result = '0;
        if (rs2_zero)
            fast_result = bus.funct3[1] ? bus.rs1_data : '1;
        else if (overflow)
            fast_result = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration: hi:lo is {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opb_reg} : '0);
    assign div_shift = {hi_reg, lo_reg[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_reg});
    assign div_sub   = div_shift[XLEN-1:0] - opb_reg;

    always_comb begin
        if (op_reg[2]) begin
            hi_step = div_ge ? div_sub : div_shift[XLEN-1:0];
            lo_step = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the last iteration's output
    always_comb begin
        prod_s = neg_reg ? -{hi_step, lo_step} : {hi_step, lo_step};
        quo_s  = neg_reg ? -lo_step : lo_step;
        rem_s  = nega_reg ? -hi_step : hi_step;
        case (op_reg)
            3'b000:                 final_result = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_result = quo_s;
            default:                final_result = rem_s;
        endcase
    end

    assign done = (state_reg == DONE);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        opb_next    = opb_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;
        nega_next   = nega_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.flush && !done) begin
                    if (fast_path) begin
                        result_next = fast_result;
                        state_next  = DONE;
                    end else begin
                        state_next = CALC;
                        count_next = '0;
                        op_next    = bus.funct3;
                        neg_next   = sign_a ^ sign_b;
                        nega_next  = sign_a;
                        hi_next    = '0;
                        // Multiply: lo = multiplier, opb = multiplicand. Divide: lo = dividend, opb = divisor.
                        lo_next    = bus.funct3[2] ? mag_a : mag_b;
                        opb_next   = bus.funct3[2] ? mag_b : mag_a;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else begin
                    count_next = count_reg + 1'b1;
                    hi_next    = hi_step;
                    lo_next    = lo_step;
                    if (count_reg == {CW{1'b1}}) begin
                        result_next = final_result;
                        state_next  = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opb_reg    <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            nega_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            opb_reg    <= opb_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
            nega_reg   <= nega_next;
            result_reg <= result_next;
        end
    end

    assign bus.busy   = (state_reg == CALC);
    assign bus.done   = done;
    assign bus.result = result_reg;
    assign bus.stall  = bus.start & ~done & ~bus.flush;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table of RV32M operations with exact latency checks,
// plus hand sequences for flush, held start and mid-operation reset.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst;

    mdu_seq_if bus ();

    mdu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int N = 23;
    vec_t tbl [N];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one operation at the current cycle and check stall/busy/done cycle by cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int lat, input int id);
        int          perr;
        logic        exp_busy, exp_done, exp_stall;
        logic [31:0] got;
        perr = 0;
        got  = 'x;
        bus.funct3   = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.start    = 1'b1;
        for (int k = 0; k <= lat + 1; k++) begin
            if (k == 1) begin
                bus.rs1_data = ~a;
                bus.rs2_data = b + 32'd1;
                bus.funct3   = f3 ^ 3'b011;
            end
            if (k == lat + 1) bus.start = 1'b0;
            @(negedge clk);
            exp_busy  = (lat > 1) && (k >= 1) && (k < lat);
            exp_done  = (k == lat);
            exp_stall = (k < lat);
            if (bus.busy !== exp_busy || bus.done !== exp_done || bus.stall !== exp_stall)
                perr++;
            if (k == lat) got = bus.result;
            next_cycle();
        end
        check($sformatf("vec%0d f3=%b timing_errs", id, f3), perr, 0);
        check($sformatf("vec%0d f3=%b result", id, f3), got, expv);
    endtask

    initial begin
        int          dcount;
        logic [31:0] prev;

        tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        tbl[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        tbl[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        tbl[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        tbl[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        tbl[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        tbl[9]  = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
        tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        tbl[12] = '{3'b000, 32'd0,        32'd12345,    32'd0,        33};
        tbl[13] = '{3'b100, 32'h80000000, 32'd3,        32'hD5555556, 33};
        tbl[14] = '{3'b110, 32'h80000000, 32'd3,        32'hFFFFFFFE, 33};
        tbl[15] = '{3'b001, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 33};
        tbl[16] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        tbl[17] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
        tbl[18] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1};
        tbl[19] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
        tbl[20] = '{3'b011, 32'h80000000, 32'd2,        32'd1,        33};
        tbl[21] = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        tbl[22] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        33};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.funct3   = 3'b000;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset result", bus.result, 0);
        check("reset stall", bus.stall, 0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < N; i++)
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, i);

        // Flush in the middle of a divide, then a multiply two cycles later
        prev         = tbl[N-1].exp;
        dcount       = 0;
        bus.funct3   = 3'b101;
        bus.rs1_data = 32'd100;
        bus.rs2_data = 32'd7;
        bus.start    = 1'b1;
        for (int k = 0; k <= 46; k++) begin
            if (k == 10) begin bus.start = 1'b0; bus.flush = 1'b1; end
            if (k == 11) bus.flush = 1'b0;
            if (k == 12) begin
                bus.funct3 = 3'b000; bus.rs1_data = 32'd3; bus.rs2_data = 32'd4; bus.start = 1'b1;
            end
            if (k == 46) bus.start = 1'b0;
            @(negedge clk);
            if (k == 10) check("flush stall", bus.stall, 0);
            if (k == 11) begin
                check("flush busy", bus.busy, 0);
                check("flush result kept", bus.result, prev);
            end
            if (k < 45 && bus.done === 1'b1) dcount++;
            if (k == 45) begin
                check("post-flush mul done", bus.done, 1);
                check("post-flush mul result", bus.result, 32'd12);
            end
            next_cycle();
        end
        check("flush stray done", dcount, 0);

        // Flush together with a fast-path request in IDLE: nothing starts
        bus.funct3 = 3'b101; bus.rs1_data = 32'd5; bus.rs2_data = 32'd0;
        bus.start  = 1'b1;   bus.flush = 1'b1;
        @(negedge clk);
        check("idle flush stall", bus.stall, 0);
        next_cycle();
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("idle flush done", bus.done, 0);
        check("idle flush busy", bus.busy, 0);
        next_cycle();

        // Start held past done: one pulse, re-accepted in IDLE, then reset mid-operation
        dcount       = 0;
        bus.funct3   = 3'b011;
        bus.rs1_data = 32'h80000000;
        bus.rs2_data = 32'd2;
        bus.start    = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (k == 39) rst = 1'b1;
            if (k == 40) begin rst = 1'b0; bus.start = 1'b0; end
            @(negedge clk);
            if (k <= 34 && bus.done === 1'b1) dcount++;
            if (k == 33) check("held mulhu result", bus.result, 32'd1);
            if (k == 34) check("held restart stall", bus.stall, 1);
            if (k == 35) check("held restart busy", bus.busy, 1);
            if (k == 40) begin
                check("midop rst busy", bus.busy, 0);
                check("midop rst done", bus.done, 0);
                check("midop rst result", bus.result, 0);
            end
            next_cycle();
        end
        check("held done pulses", dcount, 1);

        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
            next_cycle();
        end
        check("after rst quiet", dcount, 0);

        run_op(3'b000, 32'd3, 32'd4, 32'd12, 33, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
